ram_rr_arbiter: RTL



---
 rtl/ram_rr_arbiter_if.sv | 32 +++
 rtl/ram_rr_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ram_rr_arbiter_if.sv
// Core/RAM bundle for ram_rr_arbiter.
// Core side: req, wren, addr, din, gnt, dq, rdvalid.
// RAM side: ram_addr, ram_din, ram_wren, ram_q.
interface ram_rr_arbiter_if #(
  parameter int NCORES = 3,
  parameter int AW     = 8,
  parameter int DW     = 8
);
  logic [NCORES-1:0]    req;
  logic [NCORES-1:0]    wren;
  logic [NCORES*AW-1:0] addr;
  logic [NCORES*DW-1:0] din;
  logic [NCORES-1:0]    gnt;
  logic [DW-1:0]        dq;
  logic [NCORES-1:0]    rdvalid;
  logic [AW-1:0]        ram_addr;
  logic [DW-1:0]        ram_din;
  logic                 ram_wren;
  logic [DW-1:0]        ram_q;

  modport master (
    output req, wren, addr, din, ram_q,
    input  gnt, dq, rdvalid,
    input  ram_addr, ram_din, ram_wren
  );

  modport slave (
    input  req, wren, addr, din, ram_q,
    output gnt, dq, rdvalid,
    output ram_addr, ram_din, ram_wren
  );
endinterface

// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port sync RAM among NCORES.
// Ports: clk, rst (async, active-high), bus (ram_rr_arbiter_if.slave).
// Optional macro ARB_QUANTUM_EN: forced handover after QUANTUM accesses.
module ram_rr_arbiter #(
  parameter int NCORES  = 3,
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int QUANTUM = 4
) (
  input logic             clk,
  input logic             rst,
  ram_rr_arbiter_if.slave bus
);
  localparam int LW = $clog2(NCORES);

  typedef enum logic {
    S_IDLE,
    S_OWNED
  } state_t;

  state_t            r_state, w_state;
  logic [NCORES-1:0] r_gnt, w_gnt;
  logic [LW-1:0]     r_own, w_own;
  logic [LW-1:0]     r_last, w_last;
  logic [LW:0]       w_pick;
  logic              w_acc, w_rel;

  logic [AW-1:0]     r_ram_addr;
  logic [DW-1:0]     r_ram_din;
  logic              r_ram_wren;
  logic              r_v1, r_v2;
  logic [LW-1:0]     r_t1, r_t2;
  logic [DW-1:0]     r_dq;
  logic [NCORES-1:0] r_rdv;

`ifdef ARB_QUANTUM_EN
  localparam int CW = $clog2(QUANTUM + 1);
  logic [CW-1:0] r_cnt, w_cnt;
`else
  logic w_unused_q;
  assign w_unused_q = (QUANTUM > 0);
`endif

  // First requester after base; base itself is the
  // final candidate only when incl is set.
  function automatic logic [LW:0] f_pick(
    input logic [NCORES-1:0] rq,
    input logic [LW-1:0]     base,
    input logic              incl
  );
    logic [LW:0] res;
    int          j;
    res = '0;
    for (int k = NCORES; k >= 1; k--) begin
      j = int'(base) + k;
      if (j >= NCORES) j -= NCORES;
      if (rq[j] && (incl || k != NCORES))
        res = {1'b1, LW'(j)};
    end
    return res;
  endfunction

  always_comb begin
    w_state = r_state;
    w_gnt   = r_gnt;
    w_own   = r_own;
    w_last  = r_last;
    w_pick  = '0;
    w_acc   = 1'b0;
    w_rel   = 1'b0;
`ifdef ARB_QUANTUM_EN
    w_cnt   = r_cnt;
`endif
    unique case (r_state)
      S_IDLE: begin
        w_pick = f_pick(bus.req, r_last, 1'b1);
        if (w_pick[LW]) begin
          w_state = S_OWNED;
          w_own   = w_pick[LW-1:0];
          w_gnt   = NCORES'(1) << w_pick[LW-1:0];
        end
      end
      S_OWNED: begin
        w_acc = bus.req[r_own];
        w_rel = !bus.req[r_own];
`ifdef ARB_QUANTUM_EN
        // Quantum expiry hands over on the last
        // access edge itself, only if others wait.
        if (w_acc) begin
          if (r_cnt == CW'(QUANTUM - 1)) begin
            w_cnt = '0;
            if ((bus.req & ~r_gnt) != '0)
              w_rel = 1'b1;
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end
`endif
        if (w_rel) begin
          w_last = r_own;
`ifdef ARB_QUANTUM_EN
          w_cnt  = '0;
`endif
          w_pick = f_pick(bus.req, r_own, 1'b0);
          if (w_pick[LW]) begin
            w_own = w_pick[LW-1:0];
            w_gnt = NCORES'(1) << w_pick[LW-1:0];
          end else begin
            w_state = S_IDLE;
            w_gnt   = '0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_own   <= '0;
      r_last  <= LW'(NCORES - 1);
`ifdef ARB_QUANTUM_EN
      r_cnt   <= '0;
`endif
    end else begin
      r_state <= w_state;
      r_gnt   <= w_gnt;
      r_own   <= w_own;
      r_last  <= w_last;
`ifdef ARB_QUANTUM_EN
      r_cnt   <= w_cnt;
`endif
    end
  end

  // RAM port plus two-deep read tag pipeline, so
  // reads complete to their issuer after handover.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ram_addr <= '0;
      r_ram_din  <= '0;
      r_ram_wren <= 1'b0;
      r_v1       <= 1'b0;
      r_v2       <= 1'b0;
      r_t1       <= '0;
      r_t2       <= '0;
      r_dq       <= '0;
      r_rdv      <= '0;
    end else begin
      r_ram_wren <= 1'b0;
      if (w_acc) begin
        r_ram_addr <= bus.addr[int'(r_own)*AW +: AW];
        r_ram_din  <= bus.din[int'(r_own)*DW +: DW];
        r_ram_wren <= bus.wren[r_own];
      end
      r_v1  <= w_acc && !bus.wren[r_own];
      r_t1  <= r_own;
      r_v2  <= r_v1;
      r_t2  <= r_t1;
      r_rdv <= r_v2 ? (NCORES'(1) << r_t2) : '0;
      if (r_v2) r_dq <= bus.ram_q;
    end
  end

  assign bus.gnt      = r_gnt;
  assign bus.dq       = r_dq;
  assign bus.rdvalid  = r_rdv;
  assign bus.ram_addr = r_ram_addr;
  assign bus.ram_din  = r_ram_din;
  assign bus.ram_wren = r_ram_wren;
endmodule
